// File: rtl/siso_word_serializer.sv
// Word-to-bitstream front end: buffers one parallel word and streams it MSB-first with a strobe.
// Optional even-parity bit after the LSB when SISO_WORD_SERIALIZER_PARITY_EN is defined.
module siso_word_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Data_Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Shift_Data_Signal_Out,
  output logic                  Busy_Out,
  output logic                  Word_Done_Out
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HasGap = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
    StParity = 2'd3,
`endif
    StGap    = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic                  hold_full_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [CntW-1:0]       cnt_q;
  logic [GapW-1:0]       gap_q;
  logic                  done_q;
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
  logic                  parity_q;
`endif

  logic accept;
  logic shift_last;
  logic frame_end;
  logic gap_end;
  logic load_now;

  always_comb begin
    accept     = Data_Valid_In && Data_Ready_Out;
    shift_last = (state_q == StShift) && (cnt_q == CntLast);
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
    frame_end  = (state_q == StParity);
`else
    frame_end  = shift_last;
`endif
    gap_end    = (state_q == StGap) && (gap_q == GapLast);
    // Back-to-back reload only happens straight out of a frame when there is no gap.
    load_now   = hold_full_q &&
                 ((state_q == StIdle) || (frame_end && !HasGap) || gap_end);
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q     <= StIdle;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      word_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (Enable_In) begin
      done_q <= frame_end;
      if (accept) begin
        hold_data_q <= Data_In;
        hold_full_q <= 1'b1;
      end
      if (state_q == StShift) begin
        word_q <= {word_q[DATA_WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q + CntW'(1);
      end
      if (load_now) begin
        word_q      <= hold_data_q;
        hold_full_q <= 1'b0;
        cnt_q       <= '0;
        state_q     <= StShift;
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
        parity_q    <= ^hold_data_q;
`endif
      end else if (frame_end) begin
        gap_q   <= '0;
        state_q <= HasGap ? StGap : StIdle;
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
      end else if (shift_last) begin
        state_q <= StParity;
`endif
      end else if (gap_end) begin
        state_q <= StIdle;
      end else if (state_q == StGap) begin
        gap_q <= gap_q + GapW'(1);
      end
    end
  end

  // Strobe is gated by the enable so a frozen stream never shifts the downstream register.
  always_comb begin
    Data_Ready_Out        = Enable_In && !hold_full_q;
    Busy_Out              = (state_q != StIdle) || hold_full_q;
    Word_Done_Out         = done_q;
`ifdef SISO_WORD_SERIALIZER_PARITY_EN
    Shift_Data_Signal_Out = Enable_In && ((state_q == StShift) || (state_q == StParity));
    Serial_Data_Out       = (state_q == StParity) ? parity_q : word_q[DATA_WIDTH-1];
`else
    Shift_Data_Signal_Out = Enable_In && (state_q == StShift);
    Serial_Data_Out       = word_q[DATA_WIDTH-1];
`endif
  end

endmodule

// File: tb/tb_siso_word_serializer.sv
// Directed bench for siso_word_serializer: models the downstream shift register by logging
// every strobed bit and Word_Done_Out pulse, then compares against hand-computed frames.
module tb_siso_word_serializer;

`ifdef SISO_WORD_SERIALIZER_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int Frame = ParEn ? 17 : 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        serial;
  logic        strobe;
  logic        busy;
  logic        done;

  siso_word_serializer #(
    .DATA_WIDTH (16),
    .GAP_CYCLES (0)
  ) dut (
    .Clk_In                (clk),
    .Reset_In              (rst),
    .Enable_In             (en),
    .Data_In               (data),
    .Data_Valid_In         (valid),
    .Data_Ready_Out        (ready),
    .Serial_Data_Out       (serial),
    .Shift_Data_Signal_Out (strobe),
    .Busy_Out              (busy),
    .Word_Done_Out         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int q_cyc[$];
  bit q_bit[$];
  int q_done[$];
  int n_vec = 0;
  int n_err = 0;

  // Downstream register model: it shifts whatever is on the serial line when strobed.
  always @(posedge clk) begin
    if (strobe) begin
      q_cyc.push_back(cyc);
      q_bit.push_back(serial);
    end
    if (done) q_done.push_back(cyc);
    cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] frame_at(input int s);
    logic [16:0] r = '0;
    for (int i = 0; i < Frame; i++)
      r = {r[15:0], (s + i < q_bit.size()) ? q_bit[s + i] : 1'b0};
    return r;
  endfunction

  function automatic int cyc_at(input int i);
    return (i >= 0 && i < q_cyc.size()) ? q_cyc[i] : -1000;
  endfunction

  function automatic logic [16:0] exp_frame(input logic [15:0] w, input bit p);
    return ParEn ? {w, p} : {1'b0, w};
  endfunction

  task automatic send(input logic [15:0] w, output int acc);
    int t = 0;
    @(negedge clk);
    valid = 1'b1;
    data  = w;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", 32'(ready), 32'd1);
    acc = cyc;
    @(negedge clk);
    valid = 1'b0;
    data  = 16'hDEAD;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (q_done.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(q_done.size() >= n), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (q_cyc.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("bits_seen", 32'(q_cyc.size()), 32'(n));
  endtask

  int s0, s1, d0, acc;
  logic sv;

  initial begin
    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b1;
    data  = 16'hBEEF;

    // Reset, with a word offered the whole time.
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(serial), 32'd0);
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_ready",  32'(ready),  32'd1);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy",   32'(busy), 32'd0);
    check("post_rst_nobits", 32'(q_cyc.size()), 32'd0);

    // Single word.
    s0 = q_cyc.size(); d0 = q_done.size();
    send(16'hA5C3, acc);
    wait_done(d0 + 1);
    check("a5c3_frame",   32'(frame_at(s0)), 32'(exp_frame(16'hA5C3, 1'b0)));
    check("a5c3_count",   32'(q_cyc.size() - s0), 32'(Frame));
    check("a5c3_latency", 32'(cyc_at(s0) - acc), 32'd2);
    check("a5c3_span",    32'(cyc_at(s0 + Frame - 1) - cyc_at(s0) + 1), 32'(Frame));
    check("a5c3_ndone",   32'(q_done.size() - d0), 32'd1);
    check("a5c3_donepos", 32'(q_done[d0] - cyc_at(s0 + Frame - 1)), 32'd1);

    // Back-to-back words, second offered while the first streams.
    s0 = q_cyc.size(); d0 = q_done.size();
    send(16'hFFFF, acc);
    send(16'h0000, acc);
    wait_done(d0 + 2);
    check("b2b_frame0", 32'(frame_at(s0)), 32'(exp_frame(16'hFFFF, 1'b0)));
    check("b2b_frame1", 32'(frame_at(s0 + Frame)), 32'(exp_frame(16'h0000, 1'b0)));
    check("b2b_count",  32'(q_cyc.size() - s0), 32'(2 * Frame));
    check("b2b_span",   32'(cyc_at(s0 + 2 * Frame - 1) - cyc_at(s0) + 1), 32'(2 * Frame));
    check("b2b_ndone",  32'(q_done.size() - d0), 32'd2);
    check("b2b_dgap",   32'(q_done[d0 + 1] - q_done[d0]), 32'(Frame));

    // Enable dropped for 3 cycles after bit 5.
    s0 = q_cyc.size(); d0 = q_done.size();
    send(16'h8001, acc);
    wait_bits(s0 + 5);
    sv = serial;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("dis_strobe", 32'(strobe), 32'd0);
      check("dis_ready",  32'(ready),  32'd0);
      check("dis_serial", 32'(serial), 32'(sv));
      @(negedge clk);
    end
    en = 1'b1;
    wait_done(d0 + 1);
    check("en_frame",  32'(frame_at(s0)), 32'(exp_frame(16'h8001, 1'b0)));
    check("en_count",  32'(q_cyc.size() - s0), 32'(Frame));
    check("en_span",   32'(cyc_at(s0 + Frame - 1) - cyc_at(s0) + 1), 32'(Frame + 3));
    check("en_resume", 32'(cyc_at(s0 + 5) - cyc_at(s0 + 4)), 32'd4);

    // Reset mid-word with a second word held.
    s0 = q_cyc.size();
    send(16'hFFFF, acc);
    send(16'hFFFF, acc);
    wait_bits(s0 + 8);
    rst = 1'b1;
    #1;
    check("mid_rst_strobe", 32'(strobe), 32'd0);
    check("mid_rst_serial", 32'(serial), 32'd0);
    check("mid_rst_busy",   32'(busy),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    s1 = q_cyc.size();
    repeat (40) @(negedge clk);
    check("mid_rst_residual", 32'(q_cyc.size() - s1), 32'd0);
    check("mid_rst_idle",     32'(busy), 32'd0);

    s0 = q_cyc.size(); d0 = q_done.size();
    send(16'h1234, acc);
    wait_done(d0 + 1);
    check("w1234_frame",   32'(frame_at(s0)), 32'(exp_frame(16'h1234, 1'b1)));
    check("w1234_latency", 32'(cyc_at(s0) - acc), 32'd2);
    check("w1234_count",   32'(q_cyc.size() - s0), 32'(Frame));

    // Frame length / final bit (parity bit when enabled).
    s0 = q_cyc.size(); d0 = q_done.size();
    send(16'h0001, acc);
    wait_done(d0 + 1);
    check("w0001_count",   32'(q_cyc.size() - s0), 32'(Frame));
    check("w0001_lastbit", 32'(q_bit[s0 + Frame - 1]), 32'd1);
    check("w0001_frame",   32'(frame_at(s0)), 32'(exp_frame(16'h0001, 1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/siso_word_serializer.md
# siso_word_serializer

Word-to-bitstream front end for the 16-bit serial-in/serial-out shift register. Accepts parallel words over a valid/ready handshake, buffers one word, and drives the shift register's serial data and shift-strobe inputs MSB-first, one bit per clock. Its outputs connect directly to the shift register's Serial_Data_In and Shift_Data_Signal_In inputs.

## Interface
Parameters:
- DATA_WIDTH, 16, word width and data shift cycles per word (≥2).
- GAP_CYCLES, 0, idle cycles forced between consecutive words (0 = back-to-back).

Ports:
- Clk_In  in  1  single clock, rising-edge.
- Reset_In  in  1  asynchronous, active-high reset.
- Enable_In  in  1  global enable; low freezes all state.
- Data_In  in  DATA_WIDTH  parallel word from the producer.
- Data_Valid_In  in  1  producer offers Data_In.
- Data_Ready_Out  out  1  block can accept a word; equals Enable_In && holding register empty.
- Serial_Data_Out  out  1  current serial bit, to the shift register's Serial_Data_In.
- Shift_Data_Signal_Out  out  1  shift strobe, to the shift register's Shift_Data_Signal_In.
- Busy_Out  out  1  FSM not in IDLE, or holding register full.
- Word_Done_Out  out  1  one-cycle pulse after the last bit of a word is shifted.

## Operation
- Storage: holding register (DATA_WIDTH + full flag), shifter r_Word, bit counter ($clog2(DATA_WIDTH+1) bits), gap counter.
- Handshake: a word is accepted on a rising edge with Data_Valid_In && Data_Ready_Out. It is written into the holding register, and the full flag is set. Data_In is ignored when the handshake does not occur.
- IDLE: Shift_Data_Signal_Out=0. If the holding register is full, the next edge loads r_Word, clears the full flag, clears the counter, and enters SHIFT.
- SHIFT: Shift_Data_Signal_Out=1 and Serial_Data_Out=r_Word[DATA_WIDTH-1]. Each edge shifts r_Word left by one (zero fill) and increments the counter. The edge with counter=DATA_WIDTH-1 ends the data phase, then:
  - PARITY, when the macro is defined;
  - else GAP, when GAP_CYCLES>0;
  - else SHIFT with the next word loaded, when the holding register is full (no bubble);
  - else IDLE.
- PARITY: one cycle with Shift_Data_Signal_Out=1 and Serial_Data_Out=stored parity. The next transition follows the same rule as the end of SHIFT.
- GAP: Shift_Data_Signal_Out=0 for exactly GAP_CYCLES cycles, then SHIFT with the next word (if held) or IDLE.
- Word_Done_Out is registered and high for the single cycle after the edge that shifted the final bit.
- Simultaneous events: if a handshake occurs on the same edge as the final bit with the holding register empty, the word is captured and the FSM goes through IDLE, giving one bubble cycle. A handshake is never accepted while the full flag is set.
- Enable_In low: no state changes, the handshake is blocked (Data_Ready_Out=0), Shift_Data_Signal_Out=0, and Serial_Data_Out holds its value. The stream resumes at the same bit when Enable_In returns high.
- Reset: asynchronous and effective mid-word. The in-flight word and the held word are discarded.

## Timing
- Reset values:
  - Serial_Data_Out=0, Shift_Data_Signal_Out=0, Busy_Out=0, Word_Done_Out=0.
  - FSM=IDLE, full flag=0, counters=0.
  - Data_Ready_Out=Enable_In.
- Latency: handshake at edge N puts the MSB on Serial_Data_Out with the strobe high from edge N+1, when starting from IDLE.
- Frame length: DATA_WIDTH (+1 with parity) strobe cycles, plus GAP_CYCLES idle cycles.
- Serial_Data_Out and Shift_Data_Signal_Out are decoded from registers only. No combinational path runs from Data_In or Data_Valid_In to them.

## Configuration
- SISO_WORD_SERIALIZER_PARITY_EN defined: an even-parity bit (XOR of the word, computed at load) is appended after the LSB as one extra strobe cycle. The frame is DATA_WIDTH+1 cycles.
- Not defined: no PARITY state, and the frame is exactly DATA_WIDTH cycles.

## Test plan
- Reset with Enable_In=1 → all outputs 0, Data_Ready_Out=1; Data_Valid_In held high during reset is not accepted.
- Single word 16'hA5C3 → 16 strobe cycles carrying 1010_0101_1100_0011 MSB-first, then Word_Done_Out pulses once; downstream register then holds 16'hA5C3.
- 16'hFFFF then 16'h0000, second offered during the first, GAP_CYCLES=0 → 32 contiguous strobe cycles, 16 ones then 16 zeros, two Word_Done_Out pulses 16 cycles apart.
- Enable_In low for 3 cycles after bit 5 of 16'h8001 → strobe low for exactly those 3 cycles, Serial_Data_Out held, stream resumes at bit 6, total span 19 cycles.
- Reset pulse mid-word (bit 8) with a second word held → outputs 0 immediately, Data_Ready_Out=1 after release, no residual bits emitted; a new word 16'h1234 starts cleanly from its MSB.
- Macro defined, word 16'h0001 → 17 strobe cycles, final (parity) bit 1; macro undefined → 16 cycles.
